hack_screen_scanout: RTL and testbench



---
 rtl/scanout_pkg.sv | 34 +++
 rtl/scanout_timing.sv | 91 +++++++++
 rtl/hack_screen_scanout.sv | 94 +++++++++
 tb/tb_hack_screen_scanout.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/scanout_pkg.sv
// Timing defaults and framebuffer geometry shared by the Hack VGA scanout blocks.
package scanout_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  localparam int SCREEN_W      = 512;
  localparam int SCREEN_H      = 256;
  localparam int WORDS_PER_ROW = 32;
  localparam int SCREEN_WORDS  = 8192;

  // Window-relative coordinates go negative left of / above the framebuffer.
  localparam logic signed [11:0] SCR_W = 12'sd512;
  localparam logic signed [11:0] SCR_H = 12'sd256;

  function automatic logic in_span(logic signed [11:0] val, logic signed [11:0] lo,
                                   logic signed [11:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/scanout_timing.sv
// VGA raster counters and registered sync/active/frame_start decode; also exports the
// window-relative coordinates of the pixel that will be shown next cycle.
module scanout_timing
  import scanout_pkg::*;
#(
  parameter int X_OFF    = 64,
  parameter int Y_OFF    = 112,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               frame_start,
  output logic               active_next,
  output logic signed [11:0] x_next,
  output logic signed [11:0] y_next
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic signed [11:0] X_OFF_C = 12'(X_OFF);
  localparam logic signed [11:0] Y_OFF_C = 12'(Y_OFF);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic       run_q;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       active_q, active_d, frame_start_q, frame_start_d;

  // run_q is low for the cycle right after reset, so the first free-running cycle is (0,0) again.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_q) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end
    active_d      = (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d       = !((h_d >= HS_START) && (h_d < HS_END));
    vsync_d       = !((v_d >= VS_START) && (v_d < VS_END));
    frame_start_d = (h_d == 10'd0) && (v_d == 10'd0);
    x_next        = $signed({2'b00, h_d}) - X_OFF_C;
    y_next        = $signed({2'b00, v_d}) - Y_OFF_C;
    active_next   = active_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      run_q         <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      run_q         <= 1'b1;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;

endmodule

// File: rtl/hack_screen_scanout.sv
// Hack 512x256 framebuffer scanout to 640x480@60 VGA timing: word fetch and pixel shifter.
// Define SCANOUT_BORDER_EN to draw a 1-pixel outline around the framebuffer window.
module hack_screen_scanout
  import scanout_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'd0,
  parameter int          X_OFF     = 64,
  parameter int          Y_OFF     = 112,
  parameter int          H_ACTIVE  = H_ACTIVE_DEF,
  parameter int          H_FP      = H_FP_DEF,
  parameter int          H_SYNC    = H_SYNC_DEF,
  parameter int          H_BP      = H_BP_DEF,
  parameter int          V_ACTIVE  = V_ACTIVE_DEF,
  parameter int          V_FP      = V_FP_DEF,
  parameter int          V_SYNC    = V_SYNC_DEF,
  parameter int          V_BP      = V_BP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] mem_address,
  input  logic [15:0] mem_data,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        pixel,
  output logic        frame_start
);

  logic signed [11:0] x_next, y_next, x_fetch;
  logic               active_next;
  logic               row_in, in_window, fetch_slot, load_slot, on_border;
  logic [13:0]        mem_address_q, mem_address_d;
  logic [15:0]        shift_q, shift_d;
  logic               pixel_q, pixel_d;

  scanout_timing #(
    .X_OFF   (X_OFF),
    .Y_OFF   (Y_OFF),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .active     (active),
    .frame_start(frame_start),
    .active_next(active_next),
    .x_next     (x_next),
    .y_next     (y_next)
  );

  // The address goes out two pixels early; the RAM answers one cycle later, just in time to load.
  always_comb begin
    x_fetch       = x_next + 12'sd2;
    row_in        = in_span(y_next, 12'sd0, SCR_H);
    in_window     = row_in && in_span(x_next, 12'sd0, SCR_W);
    fetch_slot    = row_in && in_span(x_fetch, 12'sd0, SCR_W) && (x_fetch[3:0] == 4'd0);
    load_slot     = in_window && (x_next[3:0] == 4'd0);
    mem_address_d = fetch_slot ? BASE_ADDR + {1'b0, y_next[7:0], x_fetch[8:4]} : mem_address_q;
    shift_d       = load_slot ? mem_data : {1'b0, shift_q[15:1]};
`ifdef SCANOUT_BORDER_EN
    on_border = ((x_next == -12'sd1 || x_next == SCR_W) &&
                 in_span(y_next, -12'sd1, SCR_H + 12'sd1)) ||
                ((y_next == -12'sd1 || y_next == SCR_H) &&
                 in_span(x_next, -12'sd1, SCR_W + 12'sd1));
`else
    on_border = 1'b0;
`endif
    pixel_d = active_next && (in_window ? shift_d[0] : on_border);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address_q <= BASE_ADDR;
      shift_q       <= '0;
      pixel_q       <= 1'b0;
    end else begin
      mem_address_q <= mem_address_d;
      shift_q       <= shift_d;
      pixel_q       <= pixel_d;
    end
  end

  assign mem_address = mem_address_q;
  assign pixel       = pixel_q;

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Bench for hack_screen_scanout: default-timing, reduced-timing and wrapped-base instances
// checked every cycle against a raster model over a random RAM image.
module tb_hack_screen_scanout;

  localparam int NDUT  = 3;
  localparam int SX    = 16;
  localparam int SY    = 4;
  localparam int SHA   = 544;
  localparam int SHF   = 8;
  localparam int SHS   = 16;
  localparam int SHB   = 8;
  localparam int SVA   = 40;
  localparam int SVF   = 2;
  localparam int SVS   = 2;
  localparam int SVB   = 4;
  localparam int SFRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
  localparam int RST_T  = 20 * (SHA + SHF + SHS + SHB) + 300;
  localparam int RUN2   = SFRAME + 100;

  typedef struct {
    int base; int xoff; int yoff;
    int hact; int htot; int hss; int hse;
    int vact; int vtot; int vss; int vse;
  } cfg_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        hsync_w, vsync_w, active_w, pixel_w, fs_w;
  logic [2:0][13:0]  addr_w;
  logic [2:0][15:0]  data_w;
  logic [15:0]       ram [16384];
  cfg_t              cfg [NDUT];
  int                last_addr [NDUT];
  int                vectors = 0;
  int                miscompares = 0;
  int                tnow = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) data_w[i] <= ram[addr_w[i]];
  end

  hack_screen_scanout u_dut0 (
    .clk(clk), .reset(reset), .mem_address(addr_w[0]), .mem_data(data_w[0]),
    .hsync(hsync_w[0]), .vsync(vsync_w[0]), .active(active_w[0]),
    .pixel(pixel_w[0]), .frame_start(fs_w[0])
  );

  hack_screen_scanout #(
    .BASE_ADDR(14'd0), .X_OFF(SX), .Y_OFF(SY),
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_dut1 (
    .clk(clk), .reset(reset), .mem_address(addr_w[1]), .mem_data(data_w[1]),
    .hsync(hsync_w[1]), .vsync(vsync_w[1]), .active(active_w[1]),
    .pixel(pixel_w[1]), .frame_start(fs_w[1])
  );

  hack_screen_scanout #(
    .BASE_ADDR(14'h3FF0), .X_OFF(SX), .Y_OFF(SY),
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_dut2 (
    .clk(clk), .reset(reset), .mem_address(addr_w[2]), .mem_data(data_w[2]),
    .hsync(hsync_w[2]), .vsync(vsync_w[2]), .active(active_w[2]),
    .pixel(pixel_w[2]), .frame_start(fs_w[2])
  );

  task automatic cmp(string name, int d, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d t=%0d: got %0h, expected %0h", name, d, tnow, act, exp);
    end
  endtask

  function automatic logic expPixel(int d, int h, int v);
    int x, y, addr;
    x = h - cfg[d].xoff;
    y = v - cfg[d].yoff;
    if (!(h < cfg[d].hact && v < cfg[d].vact)) return 1'b0;
    if (x >= 0 && x < 512 && y >= 0 && y < 256) begin
      addr = (cfg[d].base + y * 32 + x / 16) % 16384;
      return ram[addr][x % 16];
    end
`ifdef SCANOUT_BORDER_EN
    if (((x == -1 || x == 512) && y >= -1 && y <= 256) ||
        ((y == -1 || y == 256) && x >= -1 && x <= 512)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic applyStimulus();
    cfg[0] = '{0, 64, 112, 640, 800, 656, 752, 480, 525, 490, 492};
    cfg[1] = '{0, SX, SY, SHA, SHA + SHF + SHS + SHB, SHA + SHF, SHA + SHF + SHS,
               SVA, SVA + SVF + SVS + SVB, SVA + SVF, SVA + SVF + SVS};
    cfg[2] = cfg[1];
    cfg[2].base = 16'h3FF0;
    for (int i = 0; i < 16384; i++) ram[i] = 16'($urandom);
    ram[0]  = 16'h0001;
    ram[31] = 16'h8000;
  endtask

  task automatic checkReset();
    for (int d = 0; d < NDUT; d++) begin
      cmp("rst_hsync", d, hsync_w[d], 1);
      cmp("rst_vsync", d, vsync_w[d], 1);
      cmp("rst_active", d, active_w[d], 0);
      cmp("rst_pixel", d, pixel_w[d], 0);
      cmp("rst_frame_start", d, fs_w[d], 0);
      cmp("rst_mem_address", d, addr_w[d], cfg[d].base);
      last_addr[d] = cfg[d].base;
    end
  endtask

  task automatic checkOutput(int t);
    int h, v, y, xf;
    for (int d = 0; d < NDUT; d++) begin
      h  = t % cfg[d].htot;
      v  = (t / cfg[d].htot) % cfg[d].vtot;
      y  = v - cfg[d].yoff;
      xf = h + 2 - cfg[d].xoff;
      if (y >= 0 && y < 256 && xf >= 0 && xf < 512 && xf % 16 == 0)
        last_addr[d] = (cfg[d].base + y * 32 + xf / 16) % 16384;
      cmp("hsync", d, hsync_w[d], !(h >= cfg[d].hss && h < cfg[d].hse));
      cmp("vsync", d, vsync_w[d], !(v >= cfg[d].vss && v < cfg[d].vse));
      cmp("active", d, active_w[d], (h < cfg[d].hact && v < cfg[d].vact));
      cmp("frame_start", d, fs_w[d], (h == 0 && v == 0));
      cmp("pixel", d, pixel_w[d], expPixel(d, h, v));
      cmp("mem_address", d, addr_w[d], last_addr[d]);
      if (d == 1 && v == 4 && (h == 16 || h == 527)) cmp("pin_word_edge", d, pixel_w[1], 1);
      if (d == 1 && h == 510 && v == 14) cmp("pin_addr_k31", d, addr_w[1], 351);
      if (d == 2 && h == 272 && v == 4) cmp("pin_wrap_pixel", d, pixel_w[2], 1);
      if (d == 2 && h == 270 && v == 4) cmp("pin_wrap_addr", d, addr_w[2], 0);
`ifdef SCANOUT_BORDER_EN
      if (d == 1 && h == 15 && v == 3) cmp("pin_border_corner", d, pixel_w[1], 1);
      if (d == 1 && h == 528 && v == 10) cmp("pin_border_right", d, pixel_w[1], 1);
      if (d == 1 && h == 14 && v == 10) cmp("pin_border_outside", d, pixel_w[1], 0);
`else
      if (d == 1 && h == 15 && v == 3) cmp("pin_no_border", d, pixel_w[1], 0);
`endif
    end
  endtask

  initial begin
    int d1_vs_low, d1_hs_low, d1_act, d1_fs_t, d0_hs_low, d0_act;
    d1_vs_low = 0; d1_hs_low = 0; d1_act = 0; d1_fs_t = -1; d0_hs_low = 0; d0_act = 0;
    applyStimulus();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset();
    reset = 1'b0;
    for (int t = 0; t <= RST_T; t++) begin
      @(negedge clk);
      tnow = t;
      checkOutput(t);
    end
    $display("[TB] mid-frame reset pulse");
    reset = 1'b1;
    @(negedge clk);
    checkReset();
    reset = 1'b0;
    for (int t = 0; t < RUN2; t++) begin
      @(negedge clk);
      tnow = t;
      checkOutput(t);
      if (t == 0) cmp("pin_restart_fs", 1, fs_w[1], 1);
      if (t < SFRAME) begin
        d1_vs_low += (vsync_w[1] == 1'b0) ? 1 : 0;
        d1_hs_low += (hsync_w[1] == 1'b0) ? 1 : 0;
        d1_act    += (active_w[1] == 1'b1) ? 1 : 0;
      end
      if (t > 0 && fs_w[1] && d1_fs_t < 0) d1_fs_t = t;
      if (t < 800) begin
        d0_hs_low += (hsync_w[0] == 1'b0) ? 1 : 0;
        d0_act    += (active_w[0] == 1'b1) ? 1 : 0;
      end
    end
    cmp("pin_line_hsync_low", 0, d0_hs_low, 96);
    cmp("pin_line_active", 0, d0_act, 640);
    cmp("pin_frame_vsync_low", 1, d1_vs_low, 1152);
    cmp("pin_frame_hsync_low", 1, d1_hs_low, 768);
    cmp("pin_frame_active", 1, d1_act, 21760);
    cmp("pin_frame_period", 1, d1_fs_t, 27648);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
